// File: rtl/rr_sel_arbiter_3.sv
// Three-channel round-robin arbiter that drives the registered select for a downstream 3:1 mux.
// A grant is held while its request stays high, but only for a bounded time when other channels are waiting.
module rr_sel_arbiter_3 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_valid
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] hold_q;
    logic [2:0]    gnt_q;
    logic [1:0]    sel_q;
    logic          vld_q;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Scan ptr, ptr+1, ptr+2 (mod 3); the first set bit wins.
    function automatic logic [1:0] pick(input logic [2:0] c, input logic [1:0] p);
        logic [1:0] i;
        logic [1:0] r;
        logic       f;
        i = p;
        r = p;
        f = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!f && c[i]) begin
                r = i;
                f = 1'b1;
            end
            i = inc3(i);
        end
        return r;
    endfunction

    logic [1:0] g_nxt;
    logic [2:0] others;
    logic [1:0] win_idle;
    logic [1:0] win_hand;
    logic       hold_max;

    // The current grantee is excluded from the candidates on both release and preemption,
    // so one arbitration result serves both handoff cases.
    assign g_nxt    = inc3(sel_q);
    assign others   = req & ~gnt_q;
    assign win_idle = pick(req, ptr_q);
    assign win_hand = pick(others, g_nxt);
    assign hold_max = (hold_q == CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b00;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && |req) begin
                        gnt_q   <= 3'b001 << win_idle;
                        sel_q   <= win_idle;
                        vld_q   <= 1'b1;
                        hold_q  <= CW'(1);
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        gnt_q   <= 3'b000;
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (!(|(req & gnt_q))) begin
                        ptr_q <= g_nxt;
                        if (|others) begin
                            gnt_q  <= 3'b001 << win_hand;
                            sel_q  <= win_hand;
                            hold_q <= CW'(1);
                        end else begin
                            gnt_q   <= 3'b000;
                            vld_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (hold_max && |others) begin
                        ptr_q  <= g_nxt;
                        gnt_q  <= 3'b001 << win_hand;
                        sel_q  <= win_hand;
                        hold_q <= CW'(1);
                    end else if (!hold_max) begin
                        hold_q <= hold_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = vld_q;
endmodule

// File: tb/tb_rr_sel_arbiter_3.sv
// Bench for rr_sel_arbiter_3: directed test-plan scenarios plus random traffic,
// checked against an integer-level model of the round-robin/hold rules.
module tb_rr_sel_arbiter_3;
    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;

    int n_chk = 0;
    int n_err = 0;

    // model state: grantee (-1 = none), pointer, hold count, last select
    int m_g    = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_sel  = 0;

    rr_sel_arbiter_3 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .sel(sel), .gnt_valid(gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input int cand, input int p);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (p + k) % 3;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int r;
        int w;
        r = int'(req);
        if (rst) begin
            m_g = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_g < 0) begin
            if (en && r != 0) begin
                w = pick(r, m_ptr);
                m_g = w; m_sel = w; m_hold = 1;
            end
        end else if (!en) begin
            m_g = -1;
        end else if (!r[m_g]) begin
            m_ptr = (m_g + 1) % 3;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_g = w; m_sel = w; m_hold = 1;
            end else begin
                m_g = -1;
            end
        end else if (m_hold == MH && (r & ~(1 << m_g)) != 0) begin
            m_ptr = (m_g + 1) % 3;
            w = pick(r & ~(1 << m_g), m_ptr);
            m_g = w; m_sel = w; m_hold = 1;
        end else begin
            m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
        end
    endtask

    // One clock: update the model from the sampled inputs, then compare just after the edge.
    task automatic step();
        logic [2:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_g >= 0));
        chk("sel", 32'(sel), 32'(m_sel));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 3'b000;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_vld", 32'(gnt_valid), 32'h0);

        // single request on ch2, held
        rst = 1'b0; en = 1'b1; req = 3'b100;
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 32'h2);
        repeat (5) step();
        chk("single_held", 32'(gnt), 32'h4);

        // fairness under full contention from a fresh pointer
        rst = 1'b1; step();
        rst = 1'b0; req = 3'b111;
        for (int c = 0; c < 16; c++) begin
            step();
            chk("fair_gnt", 32'(gnt), 32'(1 << ((c / 4) % 3)));
            chk("fair_vld", 32'(gnt_valid), 32'h1);
        end

        // release handoff ch1 -> ch0
        rst = 1'b1; step();
        rst = 1'b0; req = 3'b010; step();
        req = 3'b011; step();
        chk("hand_pre", 32'(gnt), 32'h2);
        req = 3'b001; step();
        chk("hand_gnt", 32'(gnt), 32'h1);
        chk("hand_sel", 32'(sel), 32'h0);
        chk("hand_vld", 32'(gnt_valid), 32'h1);

        // saturation without contention, then contention preempts at once
        rst = 1'b1; step();
        rst = 1'b0; req = 3'b001;
        repeat (10) begin
            step();
            chk("sat_gnt", 32'(gnt), 32'h1);
        end
        req = 3'b101; step();
        chk("sat_preempt", 32'(gnt), 32'h4);

        // enable drop mid-grant on ch2, then re-grant, then reset mid-grant
        en = 1'b0; step();
        chk("en_gnt", 32'(gnt), 32'h0);
        chk("en_vld", 32'(gnt_valid), 32'h0);
        chk("en_sel", 32'(sel), 32'h2);
        en = 1'b1; req = 3'b100; step();
        chk("en_regrant", 32'(gnt), 32'h4);
        rst = 1'b1; step();
        chk("rst_mid_gnt", 32'(gnt), 32'h0);
        chk("rst_mid_sel", 32'(sel), 32'h0);
        chk("rst_mid_vld", 32'(gnt_valid), 32'h0);

        // wrap-around: ptr goes 2 -> 0 on release of ch2
        rst = 1'b0; req = 3'b100; step();
        req = 3'b011; step();
        chk("wrap_gnt", 32'(gnt), 32'h1);
        chk("wrap_sel", 32'(sel), 32'h0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rr_sel_arbiter_3.md
# rr_sel_arbiter_3

Three-channel round-robin arbiter that generates the 2-bit select for the 3:1 channel mux directly downstream of it. It accepts per-channel request lines and issues a registered one-hot grant plus the matching `sel` code. Each grant is held while its request stays high, up to a bounded hold time, so that a channel cannot starve the others. The mux consumes `sel` unchanged; `gnt_valid` qualifies the mux output for the next stage.

## Interface

Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles a grant is held while another channel is requesting. Legal range ≥ 1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  arbitration enable. When low, the arbiter releases any grant and issues no new one.
- `req`  input  3  per-channel request; bit i corresponds to mux input i.
- `gnt`  output  3  registered one-hot grant, or 3'b000 when no grant is active.
- `sel`  output  2  registered mux select: 2'b00 selects ch0, 2'b01 selects ch1, 2'b10 selects ch2. 2'b11 is never driven.
- `gnt_valid`  output  1  high exactly when `gnt` is non-zero.

## Operation

- State machine:
  - States are IDLE and GRANT.
  - Internal state: `ptr` is a 2-bit index of the highest-priority channel (value 0..2 only). `g` is the current grantee. `hold_cnt` is `$clog2(MAX_HOLD+1)` bits wide.
- Arbitration function:
  - Scan the candidate set in the order `ptr`, `ptr+1`, `ptr+2` (all mod 3).
  - The first set bit wins.
  - All index arithmetic wraps mod 3; 2+1 yields 0.
- IDLE:
  - If `en`=1 and `req`≠0: arbitrate over `req` and register `gnt`=onehot(winner), `sel`=winner, `gnt_valid`=1, `hold_cnt`=1. Next state is GRANT.
  - Otherwise stay in IDLE with outputs unchanged.
- GRANT, evaluated each edge, in priority order:
  1. `en`=0: clear `gnt` and `gnt_valid`; go to IDLE. `ptr` is unchanged.
  2. `req[g]`=0 (release): set `ptr`=g+1.
     - If other requests are pending, arbitrate over them with the new `ptr` and grant with `hold_cnt`=1. The handoff has no idle bubble.
     - Else clear the grant and go to IDLE.
  3. `req[g]`=1, `hold_cnt`=`MAX_HOLD`, and another request is pending (preemption): set `ptr`=g+1, arbitrate over `req` with bit g masked off, grant the winner, and set `hold_cnt`=1.
  4. Otherwise keep the grant and set `hold_cnt`=min(`hold_cnt`+1, `MAX_HOLD`). The counter saturates when there is no contention.
- `sel` holds the last granted code whenever `gnt_valid`=0, so the mux output does not glitch. `sel` is meaningful only when `gnt_valid`=1.
- Invariants: `gnt` is always one-hot or zero; `gnt_valid` equals `|gnt`; when `gnt_valid`=1, `sel` equals the index of the set `gnt` bit.
- Reset:
  - Reset values: `gnt`=3'b000, `sel`=2'b00, `gnt_valid`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
  - Reset asserted mid-grant drops the grant at that edge. Reset overrides `en` and `req`.

## Timing

- Latency: 1 cycle from `req`/`en` sampled at edge N to `gnt`/`sel`/`gnt_valid` updated at edge N. No combinational path exists from any input to any output.
- Handoff on release or preemption: the new grant appears on the same edge the old one drops; `gnt_valid` stays high.
- A channel that drops its request and then re-raises it is re-arbitrated with normal round-robin priority.
- Hold bound: under continuous contention each grant lasts exactly `MAX_HOLD` cycles. Worst-case wait for a requester is 2·`MAX_HOLD` cycles after the current grant began.
- If `req` changes at the same edge as `en` falls, `en` wins and the result is no grant.

## Test plan

- Reset then single request: `rst` for 2 cycles, then `en`=1, `req`=3'b100 → one cycle later `gnt`=3'b100, `sel`=2'b10, `gnt_valid`=1, held for as long as `req[2]` stays high.
- Round-robin fairness: `req`=3'b111 held, `MAX_HOLD`=4 → grants ch0, ch1, ch2, ch0, each for exactly 4 cycles with no gaps.
- Release handoff: ch1 granted with `req`=3'b011; drop `req[1]` → next edge `gnt`=3'b001, `sel`=2'b00, `gnt_valid` never low.
- Saturation without contention: `req`=3'b001 held for 10 cycles → ch0 held throughout. Raise `req[2]` at cycle 10 → ch2 granted on the next edge.
- Enable/reset mid-grant: while ch2 is granted, drop `en` → `gnt`=0 and `gnt_valid`=0 next edge, `sel` stays 2'b10. Assert `rst` mid-grant → all outputs at reset values next edge.
- Wrap-around: `ptr`=0 after reset; grant ch2, release it with `req`=3'b011 pending → ch0 granted (`ptr` wrapped from 2 to 0), not ch1.
